// File: rtl/ldtu_encoder_param.sv
// LiTe-DTU sample encoder: packs baseline/signal/orbit/fallback samples
// into WORD_W-bit words and queues them in a small output FIFO.
module ldtu_encoder_param #(
  parameter int WORD_W     = 32,
  parameter int SIG_W      = 13,
  parameter int BAS_W      = 6,
  parameter int NBAS       = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic              CLK_,
  input  logic              reset_,
  input  logic              in_valid,
  input  logic [SIG_W-1:0]  in_data,
  input  logic              baseline_flag,
  input  logic              Orbit,
  input  logic              fallback_,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int BW = (NBAS - 1) * BAS_W;
  localparam int KW = (NBAS > 2) ? $clog2(NBAS) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  if (WORD_W != 2 + NBAS * BAS_W) begin : g_chk_bas
    $error("WORD_W must equal 2+NBAS*BAS_W");
  end
  if (WORD_W != 6 + 2 * SIG_W) begin : g_chk_sig
    $error("WORD_W must equal 6+2*SIG_W");
  end
  if (WORD_W - 8 < BW) begin : g_chk_part
    $error("partial word cannot hold NBAS-1 samples");
  end
  if (FIFO_DEPTH < 2 || (1 << PW) != FIFO_DEPTH) begin : g_chk_fifo
    $error("FIFO_DEPTH must be a power of 2 and >= 2");
  end

  localparam logic [WORD_W-1:0] C_FULL =
    WORD_W'(2'b01) << (WORD_W - 2);
  localparam logic [WORD_W-1:0] C_PART =
    WORD_W'(2'b10) << (WORD_W - 2);
  localparam logic [WORD_W-1:0] C_PAIR =
    WORD_W'(6'b001010) << (2 * SIG_W);
  localparam logic [WORD_W-1:0] C_SGL =
    (WORD_W'(6'b001011) << (2 * SIG_W)) |
    (WORD_W'(13'b0101010101010) << SIG_W);
  localparam logic [WORD_W-1:0] C_HDR =
    (WORD_W'(6'b001011) << (2 * SIG_W)) |
    (WORD_W'(13'b1111000001111) << SIG_W);
  localparam logic [WORD_W-1:0] C_FB =
    WORD_W'(4'hF) << (WORD_W - 4);

  typedef enum logic [1:0] {
    S_IDLE, S_BAS, S_SIG1, S_FB1
  } st_t;

  st_t               r_st, w_st_n;
  logic [KW-1:0]     r_k, w_k_n;
  logic [BW-1:0]     r_bas, w_bas_n;
  logic [SIG_W-1:0]  r_sig, w_sig_n;

  logic [BAS_W-1:0]  w_b;
  logic [WORD_W-1:0] w_part, w_sgl, w_hdr;
  logic [WORD_W-1:0] w_pair, w_full, w_fbw;
  logic [WORD_W-1:0] w_w0, w_w1;
  logic [1:0]        w_np;
  logic              w_pend;

  assign w_b    = in_data[BAS_W-1:0];
  assign w_part = C_PART | (WORD_W'(r_k) << (WORD_W - 8))
                | WORD_W'(r_bas);
  assign w_sgl  = C_SGL | WORD_W'(r_sig);
  assign w_hdr  = C_HDR | WORD_W'(in_data);
  assign w_pair = C_PAIR | (WORD_W'(in_data) << SIG_W)
                | WORD_W'(r_sig);
  assign w_full = C_FULL | (WORD_W'(w_b) << BW) | WORD_W'(r_bas);
  assign w_fbw  = C_FB
                | (WORD_W'(~^in_data) << (2 * SIG_W + 1))
                | (WORD_W'(~^r_sig) << (2 * SIG_W))
                | (WORD_W'(in_data) << SIG_W)
                | WORD_W'(r_sig);

  // a pending fallback sample is dropped when normal mode resumes
  assign w_pend = (r_st == S_BAS) || (r_st == S_SIG1);

  always_comb begin
    w_st_n  = r_st;
    w_k_n   = r_k;
    w_bas_n = r_bas;
    w_sig_n = r_sig;
    w_np    = 2'd0;
    w_w0    = '0;
    w_w1    = '0;
    if (in_valid) begin
      if (fallback_) begin
        w_bas_n = '0;
        w_k_n   = '0;
        if (r_st == S_FB1) begin
          w_w0   = w_fbw;
          w_np   = 2'd1;
          w_st_n = S_IDLE;
        end else begin
          w_sig_n = in_data;
          w_st_n  = S_FB1;
        end
      end else if (Orbit) begin
        w_bas_n = '0;
        w_k_n   = '0;
        w_st_n  = S_IDLE;
        if (w_pend) begin
          w_w0 = (r_st == S_BAS) ? w_part : w_sgl;
          w_w1 = w_hdr;
          w_np = 2'd2;
        end else begin
          w_w0 = w_hdr;
          w_np = 2'd1;
        end
      end else if (baseline_flag) begin
        unique case (r_st)
          S_BAS: begin
            if (r_k == KW'(NBAS - 1)) begin
              w_w0    = w_full;
              w_np    = 2'd1;
              w_bas_n = '0;
              w_k_n   = '0;
              w_st_n  = S_IDLE;
            end else begin
              w_bas_n = r_bas |
                (BW'(w_b) << (32'(r_k) * BAS_W));
              w_k_n   = r_k + KW'(1);
            end
          end
          S_SIG1: begin
            w_w0    = w_sgl;
            w_np    = 2'd1;
            w_bas_n = BW'(w_b);
            w_k_n   = KW'(1);
            w_st_n  = S_BAS;
          end
          default: begin
            w_bas_n = BW'(w_b);
            w_k_n   = KW'(1);
            w_st_n  = S_BAS;
          end
        endcase
      end else begin
        unique case (r_st)
          S_BAS: begin
            w_w0    = w_part;
            w_np    = 2'd1;
            w_bas_n = '0;
            w_k_n   = '0;
            w_sig_n = in_data;
            w_st_n  = S_SIG1;
          end
          S_SIG1: begin
            w_w0   = w_pair;
            w_np   = 2'd1;
            w_st_n = S_IDLE;
          end
          default: begin
            w_bas_n = '0;
            w_k_n   = '0;
            w_sig_n = in_data;
            w_st_n  = S_SIG1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK_ or negedge reset_) begin
    if (!reset_) begin
      r_st  <= S_IDLE;
      r_k   <= '0;
      r_bas <= '0;
      r_sig <= '0;
    end else begin
      r_st  <= w_st_n;
      r_k   <= w_k_n;
      r_bas <= w_bas_n;
      r_sig <= w_sig_n;
    end
  end

  logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_rd, r_wr;
  logic [CW-1:0]     r_cnt;
  logic [CNT_W-1:0]  r_drop;
  logic              r_ovf;

  logic              w_pop;
  logic [CW-1:0]     w_free;
  logic [1:0]        w_acc, w_drop;
  logic [CNT_W:0]    w_dsum;
  logic [CNT_W-1:0]  w_dsat;

  assign w_pop  = (r_cnt != '0) && out_ready;
  assign w_free = CW'(FIFO_DEPTH) - r_cnt + CW'(w_pop);
  // newest push is the one dropped when only one slot is free
  assign w_acc  = (CW'(w_np) <= w_free) ? w_np : w_free[1:0];
  assign w_drop = w_np - w_acc;
  assign w_dsum = {1'b0, r_drop} + (CNT_W + 1)'(w_drop);
  assign w_dsat = w_dsum[CNT_W] ? '1 : w_dsum[CNT_W-1:0];

  always_ff @(posedge CLK_) begin
    if (w_acc != 2'd0) r_mem[r_wr] <= w_w0;
    if (w_acc == 2'd2) r_mem[r_wr + PW'(1)] <= w_w1;
  end

  always_ff @(posedge CLK_ or negedge reset_) begin
    if (!reset_) begin
      r_rd   <= '0;
      r_wr   <= '0;
      r_cnt  <= '0;
      r_drop <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_rd   <= r_rd + PW'(w_pop);
      r_wr   <= r_wr + PW'(w_acc);
      r_cnt  <= r_cnt + CW'(w_acc) - CW'(w_pop);
      r_drop <= w_dsat;
      if (w_drop != 2'd0) r_ovf <= 1'b1;
    end
  end

  assign out_valid = (r_cnt != '0);
  assign out_data  = out_valid ? r_mem[r_rd] : '0;
  assign overflow  = r_ovf;
  assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_ldtu_encoder_param.sv
// Directed bench for ldtu_encoder_param.
// Expected words are hand-packed constants.
module tb_ldtu_encoder_param;

  logic        CLK_ = 1'b0;
  logic        reset_;
  logic        in_valid;
  logic [12:0] in_data;
  logic        baseline_flag;
  logic        Orbit;
  logic        fallback_;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int n_chk = 0;
  int n_err = 0;

  ldtu_encoder_param dut (
    .CLK_          (CLK_),
    .reset_        (reset_),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .baseline_flag (baseline_flag),
    .Orbit         (Orbit),
    .fallback_     (fallback_),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .overflow      (overflow),
    .drop_cnt      (drop_cnt)
  );

  always #5 CLK_ = ~CLK_;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic bf, input logic [12:0] d,
                      input logic orb, input logic fb);
    in_valid      = 1'b1;
    baseline_flag = bf;
    in_data       = d;
    Orbit         = orb;
    fallback_     = fb;
    @(negedge CLK_);
    in_valid = 1'b0;
    Orbit    = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] exp);
    chk({tag, "_v"}, 32'(out_valid), 32'd1);
    chk(tag, out_data, exp);
    out_ready = 1'b1;
    @(negedge CLK_);
    out_ready = 1'b0;
  endtask

  task automatic full_word(input logic [12:0] v);
    for (int i = 0; i < 5; i++) send(1'b1, v, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] fw(input logic [31:0] v);
    return 32'h4000_0000 | (v * 32'h0104_1041);
  endfunction

  initial begin
    reset_ = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    baseline_flag = 1'b0;
    Orbit = 1'b0;
    fallback_ = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    repeat (2) @(negedge CLK_);
    reset_ = 1'b1;
    @(negedge CLK_);

    // five baselines, consumer always ready
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) send(1'b1, 13'(i), 1'b0, 1'b0);
    chk("bas4_novalid", 32'(out_valid), 32'd0);
    send(1'b1, 13'd5, 1'b0, 1'b0);
    chk("full_v", 32'(out_valid), 32'd1);
    chk("full_d", out_data, 32'h4510_3081);
    @(negedge CLK_);
    chk("full_popped", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // partial flush then signal pair
    send(1'b1, 13'h3F, 1'b0, 1'b0);
    send(1'b1, 13'h3F, 1'b0, 1'b0);
    send(1'b0, 13'h1ABC, 1'b0, 1'b0);
    chk("part_d", out_data, 32'h8200_0FFF);
    send(1'b0, 13'h0123, 1'b0, 1'b0);
    chk("part_hold", out_data, 32'h8200_0FFF);
    pop_chk("part", 32'h8200_0FFF);
    pop_chk("pair", 32'h2824_7ABC);
    chk("pair_empty", 32'(out_valid), 32'd0);
    chk("empty_zero", out_data, 32'd0);

    // pending signal flushed ahead of orbit header
    send(1'b0, 13'h0FFF, 1'b0, 1'b0);
    send(1'b0, 13'h0005, 1'b1, 1'b0);
    pop_chk("orb_single", 32'h2D55_4FFF);
    pop_chk("orb_hdr", 32'h2FC1_E005);
    chk("orb_empty", 32'(out_valid), 32'd0);

    // orbit with baseline flag and nothing pending
    send(1'b1, 13'h1234, 1'b1, 1'b0);
    pop_chk("orb_only", 32'h2FC1_F234);

    // pending baseline discarded when fallback rises
    send(1'b1, 13'h11, 1'b0, 1'b0);
    send(1'b0, 13'h0001, 1'b0, 1'b1);
    chk("fb_no_discard_word", 32'(out_valid), 32'd0);
    send(1'b0, 13'h0003, 1'b0, 1'b1);
    pop_chk("fb_word", 32'hF800_6001);
    chk("fb_empty", 32'(out_valid), 32'd0);
    send(1'b1, 13'h0005, 1'b1, 1'b1);
    send(1'b1, 13'h0006, 1'b1, 1'b1);
    pop_chk("fb_ign_orb", 32'hFC00_C005);
    chk("fb_ign_empty", 32'(out_valid), 32'd0);
    // pending fallback sample lost on return to normal mode
    send(1'b0, 13'h0007, 1'b0, 1'b1);
    send(1'b0, 13'h0100, 1'b0, 1'b0);
    send(1'b0, 13'h0002, 1'b0, 1'b0);
    pop_chk("fb_back_pair", 32'h2800_4100);

    // overflow: six full words into four slots
    for (int v = 1; v <= 4; v++) full_word(13'(v));
    chk("ovf_before", 32'(overflow), 32'd0);
    full_word(13'd5);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_drop1", 32'(drop_cnt), 32'd1);
    full_word(13'd6);
    chk("ovf_drop2", 32'(drop_cnt), 32'd2);
    for (int v = 1; v <= 4; v++) pop_chk("ovf_drain", fw(32'(v)));
    chk("ovf_empty", 32'(out_valid), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // one free slot, two pushes: header is the dropped word
    for (int v = 7; v <= 9; v++) full_word(13'(v));
    send(1'b0, 13'h0FFF, 1'b0, 1'b0);
    send(1'b0, 13'h0005, 1'b1, 1'b0);
    chk("drop_hdr_cnt", 32'(drop_cnt), 32'd3);
    for (int v = 7; v <= 9; v++) pop_chk("keep_w", fw(32'(v)));
    pop_chk("keep_flush", 32'h2D55_4FFF);
    chk("keep_empty", 32'(out_valid), 32'd0);

    // async reset mid BAS(3) with FIFO occupied
    full_word(13'd1);
    for (int i = 0; i < 3; i++) send(1'b1, 13'h2A, 1'b0, 1'b0);
    #2;
    reset_ = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    chk("arst_drop", 32'(drop_cnt), 32'd0);
    @(negedge CLK_);
    reset_ = 1'b1;
    @(negedge CLK_);
    chk("arst_nopart", 32'(out_valid), 32'd0);
    for (int i = 1; i <= 5; i++) send(1'b1, 13'(i), 1'b0, 1'b0);
    pop_chk("arst_full", 32'h4510_3081);
    chk("arst_empty", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
